// File: rtl/seq_divider32.sv
// Multi-cycle restoring divider (DIV/DIVU) producing one quotient bit per clock.
// Optional signed support is enabled by defining SEQ_DIVIDER32_SIGNED_EN.
module seq_divider32 #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {StIdle, StBusy, StFinish} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] rem_q, quo_q, dsr_q, dvd_orig_q;
   logic             dz_q;
   logic             accept, last;
   logic [WIDTH-1:0] dvd_mag, dsr_mag;
   logic [WIDTH:0]   shifted, trial;
   logic [WIDTH-1:0] rem_n, quo_n, q_fin, r_fin;

`ifdef SEQ_DIVIDER32_SIGNED_EN
   logic dvd_neg, dsr_neg, q_neg_q, r_neg_q;

   assign dvd_neg = is_signed & dividend[WIDTH-1];
   assign dsr_neg = is_signed & divisor[WIDTH-1];
   assign dvd_mag = dvd_neg ? -dividend : dividend;
   assign dsr_mag = dsr_neg ? -divisor : divisor;
`else
   logic unused_is_signed;

   assign unused_is_signed = is_signed;
   assign dvd_mag          = dividend;
   assign dsr_mag          = divisor;
`endif

   assign accept = start && (state_q != StBusy);
   assign last   = (cnt_q == CNT_W'(WIDTH - 1));

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = StBusy;
         end
         StBusy: begin
            busy = 1'b1;
            if (last) state_d = StFinish;
         end
         StFinish: begin
            done    = 1'b1;
            state_d = start ? StBusy : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Working remainder is shifted together with the quotient register, which starts as the dividend.
   always_comb begin
      shifted = {rem_q, quo_q[WIDTH-1]};
      trial   = shifted - {1'b0, dsr_q};
      if (!trial[WIDTH]) begin
         rem_n = trial[WIDTH-1:0];
         quo_n = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
         rem_n = shifted[WIDTH-1:0];
         quo_n = {quo_q[WIDTH-2:0], 1'b0};
      end
   end

   always_comb begin
      q_fin = quo_n;
      r_fin = rem_n;
`ifdef SEQ_DIVIDER32_SIGNED_EN
      if (q_neg_q) q_fin = -quo_n;
      if (r_neg_q) r_fin = -rem_n;
`endif
      if (dz_q) begin
         q_fin = '1;
         r_fin = dvd_orig_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dsr_q       <= '0;
         dvd_orig_q  <= '0;
         dz_q        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER32_SIGNED_EN
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= dvd_mag;
            dsr_q      <= dsr_mag;
            dvd_orig_q <= dividend;
            dz_q       <= (divisor == '0);
`ifdef SEQ_DIVIDER32_SIGNED_EN
            q_neg_q    <= dvd_neg ^ dsr_neg;
            r_neg_q    <= dvd_neg;
`endif
         end else if (state_q == StBusy) begin
            cnt_q <= cnt_q + CNT_W'(1);
            rem_q <= rem_n;
            quo_q <= quo_n;
            if (last) begin
               quotient    <= q_fin;
               remainder   <= r_fin;
               div_by_zero <= dz_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_divider32.sv
// Scoreboard bench for seq_divider32: expected results are queued at start and checked at done.
module tb_seq_divider32;

   localparam bit SignedEn =
`ifdef SEQ_DIVIDER32_SIGNED_EN
      1'b1;
`else
      1'b0;
`endif

   typedef struct packed {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        busy, done, div_by_zero;
   logic [31:0] quotient, remainder;

   exp_t sb[$];
   exp_t last_exp = '0;
   int   total = 0;
   int   bad = 0;

   seq_divider32 dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .is_signed  (is_signed),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sg);
      exp_t        e;
      logic        na, nb;
      logic [31:0] ma, mb, q, r;
      na = SignedEn & sg & a[31];
      nb = SignedEn & sg & b[31];
      if (b == 32'd0) begin
         e.q  = 32'hFFFF_FFFF;
         e.r  = a;
         e.dz = 1'b1;
      end else begin
         ma   = na ? -a : a;
         mb   = nb ? -b : b;
         q    = ma / mb;
         r    = ma % mb;
         e.q  = (na ^ nb) ? -q : q;
         e.r  = na ? -r : r;
         e.dz = 1'b0;
      end
      return e;
   endfunction

   function automatic exp_t pop_exp();
      exp_t e;
      if (sb.size() == 0) e = 'x;
      else e = sb.pop_front();
      return e;
   endfunction

   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                           input bit expect_result);
      start     = 1'b1;
      dividend  = a;
      divisor   = b;
      is_signed = sg;
      if (expect_result) sb.push_back(model(a, b, sg));
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // n counts samples including the current one; -1 on timeout.
   task automatic wait_done(output int n, output int busy_cnt);
      n        = 1;
      busy_cnt = 0;
      while (done !== 1'b1 && n < 60) begin
         if (busy === 1'b1) busy_cnt++;
         @(posedge clk); #1;
         n++;
      end
      if (done !== 1'b1) n = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      total++;
      if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
         bad++;
         $display("FAIL reset busy/done/dz=%b%b%b q=%h r=%h required 000 0 0",
                  busy, done, div_by_zero, quotient, remainder);
      end
   endtask

   task automatic test_unsigned();
      int   n, bc;
      exp_t e;
      start_op(32'd100, 32'd7, 1'b0, 1'b1);
      wait_done(n, bc);
      e = pop_exp();
      total++;
      if (n !== 33) begin bad++; $display("FAIL unsigned_latency got=%0d required=33", n); end
      total++;
      if (bc !== 32) begin bad++; $display("FAIL unsigned_busy_cycles got=%0d required=32", bc); end
      total++;
      if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
         bad++;
         $display("FAIL unsigned_100_7 got q=%h r=%h dz=%b required q=%h r=%h dz=%b",
                  quotient, remainder, div_by_zero, e.q, e.r, e.dz);
      end
      last_exp = e;
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL done_pulse got done=%b busy=%b required 0 0", done, busy);
      end
   endtask

   task automatic test_unsigned_random();
      int          n, bc;
      exp_t        e;
      logic [31:0] a, b;
      for (int i = 0; i < 5; i++) begin
         a = $urandom;
         b = (i == 0) ? 32'd1 : ($urandom >> $urandom_range(0, 28));
         if (b == 32'd0) b = 32'd3;
         start_op(a, b, 1'b0, 1'b1);
         wait_done(n, bc);
         e = pop_exp();
         total++;
         if (n !== 33 || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
            bad++;
            $display("FAIL rand_%0d %h/%h got lat=%0d q=%h r=%h dz=%b required lat=33 q=%h r=%h dz=%b",
                     i, a, b, n, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
         end
         last_exp = e;
      end
   endtask

   task automatic test_div_by_zero();
      int   n, bc;
      exp_t e;
      start_op(32'h1234_5678, 32'd0, 1'b0, 1'b1);
      wait_done(n, bc);
      e = pop_exp();
      total++;
      if (n !== 33) begin bad++; $display("FAIL dz_latency got=%0d required=33", n); end
      total++;
      if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
         bad++;
         $display("FAIL div_by_zero got q=%h r=%h dz=%b required q=%h r=%h dz=%b",
                  quotient, remainder, div_by_zero, e.q, e.r, e.dz);
      end
      last_exp = e;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (div_by_zero !== 1'b1 || quotient !== e.q) begin
         bad++;
         $display("FAIL dz_hold got q=%h dz=%b required q=%h dz=1", quotient, div_by_zero, e.q);
      end
   endtask

   task automatic test_back_to_back();
      int   n, bc;
      exp_t e;
      start_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
      repeat (9) @(posedge clk);
      #1;
      // Request issued while busy must be dropped.
      start_op(32'd9, 32'd3, 1'b0, 1'b0);
      total++;
      if (busy !== 1'b1 || quotient !== last_exp.q || remainder !== last_exp.r) begin
         bad++;
         $display("FAIL hold_while_busy got busy=%b q=%h r=%h required busy=1 q=%h r=%h",
                  busy, quotient, remainder, last_exp.q, last_exp.r);
      end
      wait_done(n, bc);
      e = pop_exp();
      total++;
      if (n !== 23 || quotient !== e.q || remainder !== e.r) begin
         bad++;
         $display("FAIL ignore_start got lat=%0d q=%h r=%h required lat=23 q=%h r=%h",
                  n, quotient, remainder, e.q, e.r);
      end
      last_exp = e;
      // Restart in the done cycle.
      start_op(32'd9, 32'd3, 1'b0, 1'b1);
      total++;
      if (done !== 1'b0 || busy !== 1'b1 || quotient !== last_exp.q) begin
         bad++;
         $display("FAIL restart_in_done got done=%b busy=%b q=%h required done=0 busy=1 q=%h",
                  done, busy, quotient, last_exp.q);
      end
      wait_done(n, bc);
      e = pop_exp();
      total++;
      if (n !== 33 || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
         bad++;
         $display("FAIL back_to_back got lat=%0d q=%h r=%h dz=%b required lat=33 q=%h r=%h dz=%b",
                  n, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
      end
      last_exp = e;
   endtask

   task automatic test_reset_mid();
      int   n, bc, seen;
      exp_t e;
      start_op(32'd50, 32'd5, 1'b0, 1'b0);
      repeat (14) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++;
      if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
         bad++;
         $display("FAIL reset_mid busy/done/dz=%b%b%b q=%h r=%h required 000 0 0",
                  busy, done, div_by_zero, quotient, remainder);
      end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) seen++;
         @(posedge clk); #1;
      end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL aborted_done got pulses=%0d required=0", seen); end
      start_op(32'd50, 32'd5, 1'b0, 1'b1);
      wait_done(n, bc);
      e = pop_exp();
      total++;
      if (n !== 33 || quotient !== e.q || remainder !== e.r) begin
         bad++;
         $display("FAIL after_reset got lat=%0d q=%h r=%h required lat=33 q=%h r=%h",
                  n, quotient, remainder, e.q, e.r);
      end
      last_exp = e;
   endtask

   task automatic test_signed();
      int          n, bc;
      exp_t        e;
      logic [31:0] av[5];
      logic [31:0] bv[5];
      av = '{32'hFFFF_FFF9, 32'd7,        32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FF9C};
      bv = '{32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0,        32'hFFFF_FFF9};
      for (int i = 0; i < 5; i++) begin
         start_op(av[i], bv[i], 1'b1, 1'b1);
         wait_done(n, bc);
         e = pop_exp();
         total++;
         if (n !== 33 || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
            bad++;
            $display("FAIL signed_%0d %h/%h got lat=%0d q=%h r=%h dz=%b required lat=33 q=%h r=%h dz=%b",
                     i, av[i], bv[i], n, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
         end
         last_exp = e;
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_unsigned_random();
      test_div_by_zero();
      test_back_to_back();
      test_reset_mid();
      test_signed();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
